// File: rtl/fire4_5_expand3_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : fire4_5_expand3_writeback_if
// Desc     : Layer control, sampled vector and fire-RAM write bus for the
//            expand3 writeback stage. Parameters must match the attached
//            fire4_5_expand3_writeback instance.
// Revision : 1.0 - initial release
// ============================================================================
interface fire4_5_expand3_writeback_if #(
  parameter int DSP_NO = 128,
  parameter int WIDTH  = 16,
  parameter int AW     = 18
);
  // layer control and sampled vector from the expand3 stage
  logic             layer_start;
  logic             layer_sel;
  logic             sample;
  logic [WIDTH-1:0] ofm_in [DSP_NO];

  // fire output RAM write port and status
  logic             ram_we;
  logic             ram_bank;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_feedback;
  logic             busy;
  logic             overrun;

  modport master (
    output layer_start, layer_sel, sample, ofm_in,
    input  ram_we, ram_bank, ram_addr, ram_wdata, ram_feedback, busy, overrun
  );

  modport slave (
    input  layer_start, layer_sel, sample, ofm_in,
    output ram_we, ram_bank, ram_addr, ram_wdata, ram_feedback, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/fire4_5_expand3_writeback.sv
`default_nettype none
// ============================================================================
// Module   : fire4_5_expand3_writeback
// Desc     : Serialises each sampled expand3 channel vector into the fire
//            output RAM, one channel per cycle, at the expand3 half of the
//            pixel's channel slot. Counts pixels through a layer and pulses
//            ram_feedback after the last write. Samples that arrive while a
//            vector is still draining are dropped and flagged as overrun.
// Revision : 1.0 - initial release
// ============================================================================
module fire4_5_expand3_writeback #(
  parameter int DSP_NO    = 128,
  parameter int WIDTH     = 16,
  parameter int WOUT      = 32,
  parameter int CH_TOTAL  = 256,
  parameter int CH_OFFSET = 128,
  parameter int AW        = 18
) (
  input wire clk,
  input wire rst,
  fire4_5_expand3_writeback_if.slave bus
);

  localparam int c_chan_w = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int c_pix_w  = (WOUT * WOUT > 1) ? $clog2(WOUT * WOUT) : 1;
  localparam logic [c_chan_w-1:0] c_chan_last = c_chan_w'(DSP_NO - 1);
  localparam logic [c_pix_w-1:0]  c_pix_last  = c_pix_w'(WOUT * WOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_chan_w-1:0] r_chan;
  logic [c_pix_w-1:0]  r_pix;
  logic [WIDTH-1:0]    r_shadow [DSP_NO];
  logic                r_ram_we;
  logic                r_ram_bank;
  logic [AW-1:0]       r_ram_addr;
  logic [WIDTH-1:0]    r_ram_wdata;
  logic                r_ram_feedback;
  logic                r_fb_armed;
  logic                r_overrun;

  logic                w_last_chan;
  logic                w_accept;
  logic [AW-1:0]       w_addr;

  // The only slot where a new vector may land mid-drain is the last channel
  // of a pixel that is not the final pixel of the layer; layer_start wins.
  assign w_last_chan = (r_chan == c_chan_last);
  assign w_accept    = bus.sample && !bus.layer_start &&
                       ((r_state == S_IDLE) ||
                        ((r_state == S_DRAIN) && w_last_chan && (r_pix < c_pix_last)));

  // Modulo-2^AW arithmetic equals truncating the full-width result; with AW
  // sized to the layer the full address never exceeds the range anyway.
  assign w_addr = AW'(r_pix) * AW'(CH_TOTAL) + AW'(CH_OFFSET) + AW'(r_chan);

  // Shadow copy of the sampled vector; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow <= bus.ofm_in;
    end
  end

  // Drain FSM with registered RAM write port, feedback pulse and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_chan         <= '0;
      r_pix          <= '0;
      r_ram_we       <= 1'b0;
      r_ram_bank     <= 1'b0;
      r_ram_addr     <= '0;
      r_ram_wdata    <= '0;
      r_ram_feedback <= 1'b0;
      r_fb_armed     <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      // feedback trails the final write by one cycle via the armed flag
      r_ram_feedback <= r_fb_armed;
      r_fb_armed     <= 1'b0;
      if (bus.layer_start) begin
        r_state    <= S_IDLE;
        r_chan     <= '0;
        r_pix      <= '0;
        r_overrun  <= 1'b0;
        r_ram_bank <= bus.layer_sel;
        r_ram_we   <= 1'b0;
      end else begin
        if (bus.sample && !w_accept) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_ram_we <= 1'b0;
            if (w_accept) begin
              r_state <= S_DRAIN;
              r_chan  <= '0;
            end
          end
          S_DRAIN: begin
            r_ram_we    <= 1'b1;
            r_ram_wdata <= r_shadow[r_chan];
            r_ram_addr  <= w_addr;
            if (w_last_chan) begin
              if (r_pix == c_pix_last) begin
                r_state    <= S_DONE;
                r_fb_armed <= 1'b1;
              end else begin
                r_pix   <= r_pix + 1'b1;
                r_chan  <= '0;
                r_state <= w_accept ? S_DRAIN : S_IDLE;
              end
            end else begin
              r_chan <= r_chan + 1'b1;
            end
          end
          S_DONE: begin
            r_ram_we <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_ram_we <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ram_we       = r_ram_we;
  assign bus.ram_bank     = r_ram_bank;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_wdata    = r_ram_wdata;
  assign bus.ram_feedback = r_ram_feedback;
  assign bus.busy         = (r_state == S_DRAIN);
  assign bus.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fire4_5_expand3_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire4_5_expand3_writeback
// Desc     : Directed self-checking bench. A default-sized instance covers a
//            single vector, back-to-back vectors, overrun, priority and
//            mid-drain reset; a reduced instance (4 ch, 4x4 map) covers a full
//            layer through DONE.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire4_5_expand3_writeback;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_wr     = 0;

  fire4_5_expand3_writeback_if #(.DSP_NO(128), .WIDTH(16), .AW(18)) ifb ();
  fire4_5_expand3_writeback_if #(.DSP_NO(4),   .WIDTH(8),  .AW(7))  ifs ();

  fire4_5_expand3_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  fire4_5_expand3_writeback #(
    .DSP_NO(4), .WIDTH(8), .WOUT(4), .CH_TOTAL(8), .CH_OFFSET(4), .AW(7)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_big_write(input string tag, input int k, input int addr,
                                 input int data, input logic bank);
    check($sformatf("%s we k=%0d", tag, k), 32'(ifb.ram_we), 32'd1);
    check($sformatf("%s addr k=%0d", tag, k), 32'(ifb.ram_addr), 32'(addr));
    check($sformatf("%s data k=%0d", tag, k), 32'(ifb.ram_wdata), 32'(data));
    check($sformatf("%s bank k=%0d", tag, k), 32'(ifb.ram_bank), 32'(bank));
  endtask

  initial begin
    rst = 1'b0;
    ifb.layer_start = 1'b0; ifb.layer_sel = 1'b0; ifb.sample = 1'b0;
    ifs.layer_start = 1'b0; ifs.layer_sel = 1'b0; ifs.sample = 1'b0;
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = '0;
    for (int i = 0; i < 4; i++)   ifs.ofm_in[i] = '0;

    // ---- asynchronous reset, before any clock edge ----
    #2 rst = 1'b1;
    #1;
    check("rst we",       32'(ifb.ram_we),       32'd0);
    check("rst bank",     32'(ifb.ram_bank),     32'd0);
    check("rst addr",     32'(ifb.ram_addr),     32'd0);
    check("rst wdata",    32'(ifb.ram_wdata),    32'd0);
    check("rst feedback", 32'(ifb.ram_feedback), 32'd0);
    check("rst busy",     32'(ifb.busy),         32'd0);
    check("rst overrun",  32'(ifb.overrun),      32'd0);
    check("rst small we", 32'(ifs.ram_we),       32'd0);
    tick(); tick();
    rst = 1'b0;

    // ---- single vector: data k+1 at 128+k ----
    ifb.layer_sel = 1'b0; ifb.layer_start = 1'b1; tick(); ifb.layer_start = 1'b0;
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(i + 1);
    ifb.sample = 1'b1; tick(); ifb.sample = 1'b0;
    check("t1 busy at accept", 32'(ifb.busy),   32'd1);
    check("t1 we at accept",   32'(ifb.ram_we), 32'd0);
    for (int k = 0; k < 128; k++) begin
      tick();
      check_big_write("t1", k, 128 + k, k + 1, 1'b0);
      check($sformatf("t1 busy k=%0d", k), 32'(ifb.busy), 32'(k < 127));
    end
    tick();
    check("t1 we idle",     32'(ifb.ram_we),       32'd0);
    check("t1 addr hold",   32'(ifb.ram_addr),     32'd255);
    check("t1 data hold",   32'(ifb.ram_wdata),    32'd128);
    check("t1 busy idle",   32'(ifb.busy),         32'd0);
    check("t1 no feedback", 32'(ifb.ram_feedback), 32'd0);
    check("t1 overrun",     32'(ifb.overrun),      32'd0);

    // ---- back-to-back: second sample on the last-channel slot ----
    ifb.layer_start = 1'b1; tick(); ifb.layer_start = 1'b0;
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(32'h1000 + i);
    ifb.sample = 1'b1; tick(); ifb.sample = 1'b0;
    for (int k = 0; k < 128; k++) begin
      tick();
      check_big_write("t2a", k, 128 + k, 32'h1000 + k, 1'b0);
      check($sformatf("t2a busy k=%0d", k), 32'(ifb.busy), 32'd1);
      if (k == 126) begin
        for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(32'h2000 + i);
        ifb.sample = 1'b1;
      end
      if (k == 127) ifb.sample = 1'b0;
    end
    for (int k = 0; k < 128; k++) begin
      tick();
      check_big_write("t2b", k, 384 + k, 32'h2000 + k, 1'b0);
      check($sformatf("t2b busy k=%0d", k), 32'(ifb.busy), 32'(k < 127));
    end
    tick();
    check("t2 we idle", 32'(ifb.ram_we),  32'd0);
    check("t2 overrun", 32'(ifb.overrun), 32'd0);

    // ---- overrun: sample at chan 50 is dropped, pixel 2 completes intact ----
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(3 * i + 7);
    ifb.sample = 1'b1; tick(); ifb.sample = 1'b0;
    for (int k = 0; k < 128; k++) begin
      tick();
      check_big_write("t3", k, 640 + k, 3 * k + 7, 1'b0);
      check($sformatf("t3 overrun k=%0d", k), 32'(ifb.overrun), 32'(k >= 50));
      if (k == 49) begin
        for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'hFFFF;
        ifb.sample = 1'b1;
      end
      if (k == 50) ifb.sample = 1'b0;
    end
    tick();
    check("t3 overrun sticky", 32'(ifb.overrun), 32'd1);
    check("t3 we idle",        32'(ifb.ram_we),  32'd0);
    ifb.layer_start = 1'b1; tick(); ifb.layer_start = 1'b0;
    check("t3 overrun cleared", 32'(ifb.overrun), 32'd0);

    // ---- priority: layer_start with sample in IDLE ----
    ifb.layer_start = 1'b1; ifb.sample = 1'b1; tick();
    ifb.layer_start = 1'b0; ifb.sample = 1'b0;
    check("t4 overrun", 32'(ifb.overrun), 32'd0);
    check("t4 busy",    32'(ifb.busy),    32'd0);
    tick();
    check("t4 we",      32'(ifb.ram_we),  32'd0);
    check("t4 busy2",   32'(ifb.busy),    32'd0);

    // ---- mid-drain reset at chan 60, then sample without layer_start ----
    ifb.layer_sel = 1'b1; ifb.layer_start = 1'b1; tick(); ifb.layer_start = 1'b0;
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(32'h5000 + i);
    ifb.sample = 1'b1; tick(); ifb.sample = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      check_big_write("t5a", k, 128 + k, 32'h5000 + k, 1'b1);
    end
    #2 rst = 1'b1;
    #1;
    check("t5 rst we",       32'(ifb.ram_we),       32'd0);
    check("t5 rst bank",     32'(ifb.ram_bank),     32'd0);
    check("t5 rst addr",     32'(ifb.ram_addr),     32'd0);
    check("t5 rst wdata",    32'(ifb.ram_wdata),    32'd0);
    check("t5 rst feedback", 32'(ifb.ram_feedback), 32'd0);
    check("t5 rst busy",     32'(ifb.busy),         32'd0);
    check("t5 rst overrun",  32'(ifb.overrun),      32'd0);
    tick();
    check("t5 rst held we",  32'(ifb.ram_we),       32'd0);
    rst = 1'b0;
    ifb.layer_sel = 1'b0;
    for (int i = 0; i < 128; i++) ifb.ofm_in[i] = 16'(100 + i);
    ifb.sample = 1'b1; tick(); ifb.sample = 1'b0;
    for (int k = 0; k < 128; k++) begin
      tick();
      check_big_write("t5b", k, 128 + k, 100 + k, 1'b0);
    end
    tick();
    check("t5 we idle", 32'(ifb.ram_we), 32'd0);

    // ---- full layer on the reduced instance, fire5 bank ----
    ifs.layer_sel = 1'b1; ifs.layer_start = 1'b1; tick(); ifs.layer_start = 1'b0;
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 4; i++) ifs.ofm_in[i] = 8'(p * 16 + i + 1);
      ifs.sample = 1'b1; tick(); ifs.sample = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (ifs.ram_we === 1'b1) n_wr++;
        check($sformatf("t6 we p=%0d k=%0d", p, k),   32'(ifs.ram_we),       32'd1);
        check($sformatf("t6 addr p=%0d k=%0d", p, k), 32'(ifs.ram_addr),     32'(p * 8 + 4 + k));
        check($sformatf("t6 data p=%0d k=%0d", p, k), 32'(ifs.ram_wdata),    32'(p * 16 + k + 1));
        check($sformatf("t6 bank p=%0d k=%0d", p, k), 32'(ifs.ram_bank),     32'd1);
        check($sformatf("t6 fb p=%0d k=%0d", p, k),   32'(ifs.ram_feedback), 32'd0);
      end
      tick();
      check($sformatf("t6 we gap p=%0d", p), 32'(ifs.ram_we),       32'd0);
      check($sformatf("t6 fb p=%0d", p),     32'(ifs.ram_feedback), 32'(p == 15));
    end
    check("t6 last addr", 32'(ifs.ram_addr), 32'd127);
    check("t6 overrun",   32'(ifs.overrun),  32'd0);
    tick();
    check("t6 fb one cycle", 32'(ifs.ram_feedback), 32'd0);
    check("t6 write count",  32'(n_wr),             32'd64);
    check("t6 busy done",    32'(ifs.busy),         32'd0);
    ifs.sample = 1'b1; tick(); ifs.sample = 1'b0;
    check("t6 done overrun", 32'(ifs.overrun), 32'd1);
    check("t6 done we",      32'(ifs.ram_we),  32'd0);
    tick();
    check("t6 done we2",     32'(ifs.ram_we),       32'd0);
    check("t6 done addr",    32'(ifs.ram_addr),     32'd127);
    check("t6 done fb",      32'(ifs.ram_feedback), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fire4_5_expand3_writeback.md
FIRE4_5_EXPAND3_WRITEBACK -- requirements
Module: fire4_5_expand3_writeback

Interface
REQ-001 SHALL have parameter DSP_NO, default 128, the number of channels per sampled vector.
REQ-002 SHALL have parameter WIDTH, default 16, the bits per channel value.
REQ-003 SHALL have parameter WOUT, default 32, the output map side, giving WOUT*WOUT pixels per layer.
REQ-004 SHALL have parameter CH_TOTAL, default 256, the channels per pixel in the fire output RAM (expand1 and expand3 concatenated).
REQ-005 SHALL have parameter CH_OFFSET, default 128, the channel index of expand3 channel 0 within a pixel.
REQ-006 SHALL have parameter AW, default 18, the RAM address width, equal to clog2(WOUT*WOUT*CH_TOTAL).
REQ-007 clk  input  1  the single clock; all state is on the rising edge.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 layer_start  input  1  one-cycle pulse that begins a layer.
REQ-010 layer_sel  input  1  layer select sampled at layer_start; 0 = fire4, 1 = fire5.
REQ-011 sample  input  1  one-cycle pulse from the expand3 stage meaning the ofm_in vector is valid this cycle.
REQ-012 ofm_in  input  DSP_NO x WIDTH  unpacked array of the post-ReLU channel results.
REQ-013 ram_we  output  1  write strobe to the fire output RAM.
REQ-014 ram_bank  output  1  the latched layer_sel, selecting the fire4 or fire5 RAM.
REQ-015 ram_addr  output  AW  the write address.
REQ-016 ram_wdata  output  WIDTH  the write data.
REQ-017 ram_feedback  output  1  one-cycle pulse after the final write of a layer.
REQ-018 busy  output  1  high in the DRAIN state.
REQ-019 overrun  output  1  sticky flag; a sample was dropped.

Function
REQ-020 SHALL implement three states: IDLE, DRAIN and DONE.
REQ-021 SHALL hold a shadow register of DSP_NO x WIDTH bits, a channel counter chan (0..DSP_NO-1) and a pixel counter pix (0..WOUT*WOUT-1).
REQ-022 layer_start SHALL, in any state:
- go to IDLE;
- clear pix, chan and overrun;
- latch layer_sel into ram_bank.
REQ-023 layer_start SHALL take priority over a simultaneous sample; that sample is ignored and overrun is not set.
REQ-024 A sample SHALL be accepted when the state is IDLE, or when the state is DRAIN with chan==DSP_NO-1 and pix<WOUT*WOUT-1.
REQ-025 On acceptance, SHALL capture ofm_in into the shadow register at that edge, set chan=0 and enter or remain in DRAIN.
REQ-026 A sample that is not accepted SHALL be dropped and SHALL set overrun to 1.
- This covers DRAIN with chan<DSP_NO-1.
- This covers DONE.
- overrun stays 1 until layer_start or rst.
REQ-027 In DRAIN, each cycle SHALL drive the following, registered:
- ram_we=1;
- ram_wdata=shadow[chan];
- ram_addr=pix*CH_TOTAL+CH_OFFSET+chan, truncated to AW bits.
REQ-028 In DRAIN, chan SHALL then increment.
REQ-029 Latency: for a sample accepted at edge T, channel k SHALL be written in the cycle starting at edge T+1+k, so one vector takes DSP_NO cycles.
REQ-030 After the write with chan==DSP_NO-1:
- if pix<WOUT*WOUT-1: increment pix and go to IDLE, unless a back-to-back sample is accepted per REQ-024;
- if pix==WOUT*WOUT-1: go to DONE.
REQ-031 Entering DONE SHALL assert ram_feedback for exactly one cycle, the cycle after the final write.
REQ-032 DONE SHALL be held until layer_start or rst.
REQ-033 ram_we SHALL be 0 in IDLE and DONE, and ram_addr/ram_wdata SHALL hold their last values there.
REQ-034 busy SHALL equal (state==DRAIN).
REQ-035 The address arithmetic SHALL be unsigned, with no wrap below WOUT*WOUT*CH_TOTAL; the highest address written is (WOUT*WOUT-1)*CH_TOTAL+CH_OFFSET+DSP_NO-1.

Reset
REQ-036 While rst=1, regardless of clk, the state SHALL be IDLE and the following SHALL all be 0: pix, chan, ram_we, ram_bank, ram_addr, ram_wdata, ram_feedback, busy, overrun.
REQ-037 The shadow register SHALL have no reset.
REQ-038 rst asserted mid-DRAIN SHALL abort the vector with no further writes.
REQ-039 After rst is deasserted, the block SHALL accept a sample without needing a layer_start, with ram_bank=0 (fire4).

Verification
REQ-040 Single vector: layer_start with layer_sel=0, then sample with ofm_in[k]=k+1 -> 128 writes of data 1..128 at addresses 128..255, ram_bank=0, busy for 128 cycles.
REQ-041 Back-to-back: a second sample is accepted in the cycle of the chan=127 write -> pixel 1 writes at addresses 384..511 start the next cycle, with no idle gap.
REQ-042 Overrun: sample at chan=50 -> sample dropped, overrun=1, the current vector completes intact, and a later layer_start clears overrun.
REQ-043 Full layer fire5: layer_sel=1, 1024 samples spaced 289 cycles apart -> 131072 writes, last address 262143, one ram_feedback pulse, then a sample in DONE sets overrun and produces no write.
REQ-044 Mid-operation reset: rst pulsed during chan=60 -> ram_we drops at once and all outputs are 0; the next sample then writes at addresses 128..255.
REQ-045 Priority: layer_start and sample in the same cycle while IDLE -> no write and overrun stays 0.
